fp_sorter: RTL and testbench

- Orders two IEEE-754 single-precision operands by magnitude, ignoring sign, ahead of the floating-point adder's alignment stage.
- Outputs the larger-magnitude operand on bign and the smaller on smalln, together with a swap flag and the exponent difference used by the alignment shifter.
- Single registered stage: latency of one clock.

---
 rtl/fp_sorter_if.sv | 34 +++
 rtl/fp_sorter.sv | 90 +++++++++
 tb/tb_fp_sorter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fp_sorter_if.sv
// Operand-pair handshake between the adder front end and the magnitude sorter.
// The master drives operand pairs in and the slave returns the ordered result.
interface fp_sorter_if;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] bign;
  logic [31:0] smalln;
  logic        swapped;
  logic [7:0]  exp_diff;

  modport master (
    output in_valid,
    output a,
    output b,
    input  out_valid,
    input  bign,
    input  smalln,
    input  swapped,
    input  exp_diff
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output out_valid,
    output bign,
    output smalln,
    output swapped,
    output exp_diff
  );
endinterface

// File: rtl/fp_sorter.sv
// Single-precision operand sorter ahead of the FP adder's alignment shifter.
// Orders a/b by unsigned {exp,frac} magnitude and registers the result once.
package fp;
  localparam int EXPONENT_BITS = 8;
  localparam int FRACTION_BITS = 23;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exp;
    logic [FRACTION_BITS-1:0] frac;
  } float;
endpackage

module fp_sorter (
  input logic         clk,
  input logic         reset,
  fp_sorter_if.slave  bus
);
  fp::float                       a_s;
  fp::float                       b_s;
  logic [30:0]                    key_a_s;
  logic [30:0]                    key_b_s;
  logic                           swap_s;

  fp::float                       bign_d;
  fp::float                       bign_q;
  fp::float                       smalln_d;
  fp::float                       smalln_q;
  logic                           swapped_d;
  logic                           swapped_q;
  logic [fp::EXPONENT_BITS-1:0]   exp_diff_d;
  logic [fp::EXPONENT_BITS-1:0]   exp_diff_q;
  logic                           out_valid_d;
  logic                           out_valid_q;

  // Magnitude compare and selection; ties keep a on the big side.
  always_comb begin
    a_s     = fp::float'(bus.a);
    b_s     = fp::float'(bus.b);
    key_a_s = {a_s.exp, a_s.frac};
    key_b_s = {b_s.exp, b_s.frac};
    swap_s  = (key_b_s > key_a_s);
  end

  // Next-state for the result registers; data holds while no pair arrives.
  always_comb begin
    bign_d      = bign_q;
    smalln_d    = smalln_q;
    swapped_d   = swapped_q;
    exp_diff_d  = exp_diff_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      if (swap_s) begin
        bign_d   = b_s;
        smalln_d = a_s;
      end else begin
        bign_d   = a_s;
        smalln_d = b_s;
      end
      swapped_d  = swap_s;
      // bign.exp >= smalln.exp by construction, so this never wraps
      exp_diff_d = bign_d.exp - smalln_d.exp;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Result register with synchronous reset taking priority over in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      bign_q      <= '0;
      smalln_q    <= '0;
      swapped_q   <= 1'b0;
      exp_diff_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      bign_q      <= bign_d;
      smalln_q    <= smalln_d;
      swapped_q   <= swapped_d;
      exp_diff_q  <= exp_diff_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.bign      = bign_q;
  assign bus.smalln    = smalln_q;
  assign bus.swapped   = swapped_q;
  assign bus.exp_diff  = exp_diff_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_fp_sorter.sv
// Directed self-checking bench for fp_sorter: ordering, ties, specials,
// back-to-back throughput, hold on idle and reset priority.
module tb_fp_sorter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fp_sorter_if bus ();

  fp_sorter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.bign !== 32'h0) begin errors++; $display("FAIL reset bign got=%h exp=0", bus.bign); end
    checks++;
    if (bus.smalln !== 32'h0) begin errors++; $display("FAIL reset smalln got=%h exp=0", bus.smalln); end
    checks++;
    if (bus.swapped !== 1'b0 || bus.exp_diff !== 8'h00) begin
      errors++; $display("FAIL reset swap/diff got=%b/%h exp=0/00", bus.swapped, bus.exp_diff);
    end
    reset = 1'b0;
  endtask

  task automatic test_ordering();
    // a, b, bign, smalln, swapped, exp_diff
    logic [31:0] va [10] = '{32'h42923456, 32'h3F800001, 32'h40222222, 32'h40111111, 32'h40333333,
                             32'h00000000, 32'h3F800000, 32'h7FC00000, 32'h007FFFFF, 32'h00000000};
    logic [31:0] vb [10] = '{32'h40654321, 32'h408AAAAA, 32'h40111111, 32'h40222222, 32'h40333333,
                             32'h80000000, 32'hC0000000, 32'h7F800000, 32'h00800000, 32'h7F800000};
    logic [31:0] eb [10] = '{32'h42923456, 32'h408AAAAA, 32'h40222222, 32'h40222222, 32'h40333333,
                             32'h00000000, 32'hC0000000, 32'h7FC00000, 32'h00800000, 32'h7F800000};
    logic [31:0] es [10] = '{32'h40654321, 32'h3F800001, 32'h40111111, 32'h40111111, 32'h40333333,
                             32'h80000000, 32'h3F800000, 32'h7F800000, 32'h007FFFFF, 32'h00000000};
    logic        ew [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  ed [10] = '{8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'hFF};
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = va[i];
      bus.b        = vb[i];
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL order[%0d] out_valid got=%b exp=1", i, bus.out_valid); end
      checks++;
      if (bus.bign !== eb[i]) begin errors++; $display("FAIL order[%0d] bign got=%h exp=%h", i, bus.bign, eb[i]); end
      checks++;
      if (bus.smalln !== es[i]) begin errors++; $display("FAIL order[%0d] smalln got=%h exp=%h", i, bus.smalln, es[i]); end
      checks++;
      if (bus.swapped !== ew[i]) begin errors++; $display("FAIL order[%0d] swapped got=%b exp=%b", i, bus.swapped, ew[i]); end
      checks++;
      if (bus.exp_diff !== ed[i]) begin errors++; $display("FAIL order[%0d] exp_diff got=%h exp=%h", i, bus.exp_diff, ed[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3] = '{32'h41000000, 32'h3F000000, 32'hC1200000};
    logic [31:0] vb [3] = '{32'h40000000, 32'h42000000, 32'h41200000};
    logic [31:0] eb [3] = '{32'h41000000, 32'h42000000, 32'hC1200000};
    logic        ew [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0]  ed [3] = '{8'h02, 8'h06, 8'h00};
    bus.in_valid = 1'b1;
    bus.a        = va[0];
    bus.b        = vb[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.bign !== eb[i] || bus.swapped !== ew[i] || bus.exp_diff !== ed[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got v=%b bign=%h sw=%b d=%h exp v=1 bign=%h sw=%b d=%h",
                 i, bus.out_valid, bus.bign, bus.swapped, bus.exp_diff, eb[i], ew[i], ed[i]);
      end
      if (i < 2) begin
        bus.a = va[i+1];
        bus.b = vb[i+1];
      end
    end
  endtask

  task automatic test_hold();
    bus.in_valid = 1'b1;
    bus.a        = 32'h3F800000;
    bus.b        = 32'h40400000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 32'h7F7FFFFF;
    bus.b        = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.bign !== 32'h40400000 || bus.smalln !== 32'h3F800000) begin
      errors++; $display("FAIL hold data got=%h/%h exp=40400000/3f800000", bus.bign, bus.smalln);
    end
    checks++;
    if (bus.swapped !== 1'b1 || bus.exp_diff !== 8'h01) begin
      errors++; $display("FAIL hold swap/diff got=%b/%h exp=1/01", bus.swapped, bus.exp_diff);
    end
  endtask

  task automatic test_reset_priority();
    bus.in_valid = 1'b1;
    bus.a        = 32'h00000001;
    bus.b        = 32'h7F800000;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.bign !== 32'h0 || bus.smalln !== 32'h0 ||
        bus.swapped !== 1'b0 || bus.exp_diff !== 8'h00) begin
      errors++;
      $display("FAIL reset_priority got v=%b bign=%h small=%h sw=%b d=%h exp all zero",
               bus.out_valid, bus.bign, bus.smalln, bus.swapped, bus.exp_diff);
    end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.bign !== 32'h0) begin
      errors++; $display("FAIL reset_discard got v=%b bign=%h exp v=0 bign=0", bus.out_valid, bus.bign);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ordering();
    test_back_to_back();
    test_hold();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
